// File: rtl/matrix_alu_scheduler_if.sv
// Command, response and ALU-control signals shared by the scheduler and its environment.
interface matrix_alu_scheduler_if #(
    parameter int CNT_W = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_opcode;
    logic [15:0]      req0_scalar;
    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_opcode;
    logic [15:0]      req1_scalar;
    logic             resp_valid;
    logic             resp_id;
    logic [1:0]       resp_status;
    logic             alu_start;
    logic [2:0]       alu_opcode;
    logic [15:0]      alu_scalar;
    logic             alu_done;
    logic             alu_error;
    logic             busy;
    logic             fault;
    logic [CNT_W-1:0] ok_count;

    modport master (
        output req0_valid, req0_opcode, req0_scalar,
        output req1_valid, req1_opcode, req1_scalar,
        output alu_done, alu_error,
        input  req0_ready, req1_ready, resp_valid, resp_id, resp_status,
        input  alu_start, alu_opcode, alu_scalar, busy, fault, ok_count
    );

    modport slave (
        input  req0_valid, req0_opcode, req0_scalar,
        input  req1_valid, req1_opcode, req1_scalar,
        input  alu_done, alu_error,
        output req0_ready, req1_ready, resp_valid, resp_id, resp_status,
        output alu_start, alu_opcode, alu_scalar, busy, fault, ok_count
    );
endinterface

// File: rtl/matrix_alu_scheduler.sv
// Shares one matrix ALU between two requesters; response = ALU run cycles + 3 (illegal opcode: next cycle).
// Ready is offered only in IDLE to the arbitration winner; a hung ALU locks the block in FAULT until reset.
module matrix_alu_scheduler #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 8
) (
    input logic                   clk,
    input logic                   rst_n,
    matrix_alu_scheduler_if.slave bus
);
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_RUN     = 3'd2,
        S_RELEASE = 3'd3,
        S_RESP    = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_last_grant;
    logic             r_cmd_id;
    logic             r_alu_start;
    logic [2:0]       r_alu_opcode;
    logic [15:0]      r_alu_scalar;
    logic [1:0]       r_status;
    logic             r_resp_id;
    logic [1:0]       r_resp_status;
    logic [WD_W-1:0]  r_wdog;
    logic             r_fault;
    logic [CNT_W-1:0] r_ok_count;

    logic             w_grant;
    logic             w_accept;
    logic             w_illegal;
    logic             w_wdog_exp;
    logic [2:0]       w_opcode;
    logic [15:0]      w_scalar;

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            w_grant = ~r_last_grant;
        end else if (bus.req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_accept   = (r_state == S_IDLE) && (bus.req0_valid || bus.req1_valid);
    assign w_opcode   = w_grant ? bus.req1_opcode : bus.req0_opcode;
    assign w_scalar   = w_grant ? bus.req1_scalar : bus.req0_scalar;
    assign w_illegal  = (w_opcode > 3'd4);
    assign w_wdog_exp = (r_wdog == WD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_illegal ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE:   w_next = S_RUN;
            S_RUN: begin
                if (bus.alu_error || bus.alu_done) begin
                    w_next = S_RELEASE;
                end else if (w_wdog_exp) begin
                    w_next = S_RESP;
                end
            end
            S_RELEASE: w_next = S_RESP;
            S_RESP:    w_next = (r_resp_status == 2'b10) ? S_FAULT : S_IDLE;
            S_FAULT:   w_next = S_FAULT;
            default:   w_next = S_IDLE;
        endcase
    end

    // Response id/status are loaded on entry to RESP and then held until the next response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant  <= 1'b1;
            r_cmd_id      <= 1'b0;
            r_alu_start   <= 1'b0;
            r_alu_opcode  <= 3'd0;
            r_alu_scalar  <= 16'd0;
            r_status      <= 2'b00;
            r_resp_id     <= 1'b0;
            r_resp_status <= 2'b00;
            r_wdog        <= '0;
            r_fault       <= 1'b0;
            r_ok_count    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_last_grant <= w_grant;
                        r_cmd_id     <= w_grant;
                        if (w_illegal) begin
                            r_resp_id     <= w_grant;
                            r_resp_status <= 2'b11;
                        end else begin
                            r_alu_start  <= 1'b1;
                            r_alu_opcode <= w_opcode;
                            r_alu_scalar <= w_scalar;
                        end
                    end
                end
                S_RUN: begin
                    r_wdog <= r_wdog + WD_W'(1);
                    if (bus.alu_error) begin
                        r_status    <= 2'b01;
                        r_alu_start <= 1'b0;
                    end else if (bus.alu_done) begin
                        r_status    <= 2'b00;
                        r_alu_start <= 1'b0;
                    end else if (w_wdog_exp) begin
                        r_resp_id     <= r_cmd_id;
                        r_resp_status <= 2'b10;
                        r_alu_start   <= 1'b0;
                    end
                end
                S_RELEASE: begin
                    r_resp_id     <= r_cmd_id;
                    r_resp_status <= r_status;
                end
                S_RESP: begin
                    r_wdog <= '0;
                    if (r_resp_status == 2'b00) begin
                        r_ok_count <= r_ok_count + CNT_W'(1);
                    end
                    if (r_resp_status == 2'b10) begin
                        r_fault <= 1'b1;
                    end
                end
                S_FAULT: begin
                    r_alu_start <= 1'b0;
                end
                default: begin
                    r_alu_start <= r_alu_start;
                end
            endcase
        end
    end

    assign bus.req0_ready  = (r_state == S_IDLE) && !w_grant;
    assign bus.req1_ready  = (r_state == S_IDLE) && w_grant;
    assign bus.resp_valid  = (r_state == S_RESP);
    assign bus.resp_id     = r_resp_id;
    assign bus.resp_status = r_resp_status;
    assign bus.alu_start   = r_alu_start;
    assign bus.alu_opcode  = r_alu_opcode;
    assign bus.alu_scalar  = r_alu_scalar;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.fault       = r_fault;
    assign bus.ok_count    = r_ok_count;
endmodule

// File: tb/tb_matrix_alu_scheduler.sv
// Directed bench: timeline model of each command checked every cycle, plus literal per-test expectations.
module tb_matrix_alu_scheduler;
    localparam int TO    = 16;
    localparam int CW    = 8;
    localparam int NEVER = 1 << 30;
    localparam int M_OK = 0, M_ERR = 1, M_HANG = 2, M_STALE = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matrix_alu_scheduler_if #(.CNT_W(CW)) bus();
    matrix_alu_scheduler #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int alu_mode = M_OK;
    int alu_lat = 1;
    int n_start = 0;

    time        rq_t[$];
    bit         rq_id[$];
    logic [1:0] rq_st[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ALU stand-in: done (or error) once start has been high for alu_lat+1 cycles.
    initial begin : alu_model
        int scnt;
        scnt = 0;
        bus.alu_done = 1'b0;
        bus.alu_error = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!bus.alu_start) begin
                scnt = 0;
                bus.alu_done = 1'b0;
            end else begin
                scnt++;
                if (scnt == 1) bus.alu_error = (alu_mode == M_STALE);
                else if (alu_mode == M_STALE) bus.alu_error = 1'b0;
                if (alu_mode != M_HANG && scnt >= alu_lat + 1) begin
                    if (alu_mode == M_ERR) bus.alu_error = 1'b1;
                    else bus.alu_done = 1'b1;
                end
            end
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.alu_start) n_start++;
                if (bus.resp_valid) begin
                    rq_t.push_back($time);
                    rq_id.push_back(bus.resp_id);
                    rq_st.push_back(bus.resp_status);
                end
            end
        end
    end

    // Model: each accepted command is turned into a cycle timeline (start window, response cycle, idle/fault cycle).
    int         m_free, m_slo, m_shi, m_ohi, m_resp, m_fault_at, m_ok;
    bit         m_last, m_rid, m_rid_n;
    logic [1:0] m_rst, m_rst_n;
    logic [2:0] m_op;
    logic [15:0] m_sc;

    function automatic void model_reset();
        m_free = 0; m_slo = NEVER; m_shi = -1; m_ohi = -1; m_resp = -1;
        m_fault_at = NEVER; m_ok = 0; m_last = 1'b1;
        m_rid = 1'b0; m_rid_n = 1'b0; m_rst = 2'b00; m_rst_n = 2'b00;
        m_op = 3'd0; m_sc = 16'd0;
    endfunction

    initial begin : compare
        bit idle, g, v0, v1;
        int r;
        logic [2:0] op;
        model_reset();
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                model_reset();
            end else begin
                idle = (cyc >= m_free) && (cyc < m_fault_at);
                v0 = bus.req0_valid;
                v1 = bus.req1_valid;
                g = (v0 && v1) ? !m_last : v1;
                if (cyc == m_resp) begin
                    m_rid = m_rid_n;
                    m_rst = m_rst_n;
                end
                chk("req0_ready", bus.req0_ready, idle && !g);
                chk("req1_ready", bus.req1_ready, idle && g);
                chk("busy", bus.busy, !idle);
                chk("alu_start", bus.alu_start, cyc >= m_slo && cyc <= m_shi);
                if (cyc >= m_slo && cyc <= m_ohi) begin
                    chk("alu_opcode", bus.alu_opcode, m_op);
                    chk("alu_scalar", bus.alu_scalar, m_sc);
                end
                chk("resp_valid", bus.resp_valid, cyc == m_resp);
                chk("resp_id", bus.resp_id, m_rid);
                chk("resp_status", bus.resp_status, m_rst);
                chk("fault", bus.fault, cyc >= m_fault_at);
                chk("ok_count", bus.ok_count, m_ok);
                if (cyc == m_resp && m_rst == 2'b00) m_ok = (m_ok + 1) % (1 << CW);
                if (idle && (v0 || v1)) begin
                    op = g ? bus.req1_opcode : bus.req0_opcode;
                    m_last = g;
                    m_rid_n = g;
                    if (op > 3'd4) begin
                        m_resp = cyc + 1; m_rst_n = 2'b11; m_free = cyc + 2;
                    end else begin
                        r = (alu_mode == M_HANG) ? TO : alu_lat;
                        m_op = op;
                        m_sc = g ? bus.req1_scalar : bus.req0_scalar;
                        m_slo = cyc + 1;
                        m_shi = cyc + 1 + r;
                        if (alu_mode == M_HANG) begin
                            m_ohi = m_shi; m_resp = cyc + r + 2; m_rst_n = 2'b10;
                            m_fault_at = cyc + r + 3; m_free = NEVER;
                        end else begin
                            m_ohi = m_shi + 1; m_resp = cyc + r + 3;
                            m_rst_n = (alu_mode == M_ERR) ? 2'b01 : 2'b00;
                            m_free = cyc + r + 4;
                        end
                    end
                end
            end
        end
    end

    task automatic wait_accept(output bit acc, output bit which, output time ta);
        acc = 1'b0; which = 1'b0; ta = 0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            if (bus.req0_valid && bus.req0_ready) begin acc = 1'b1; which = 1'b0; ta = $time; end
            else if (bus.req1_valid && bus.req1_ready) begin acc = 1'b1; which = 1'b1; ta = $time; end
        end
        chk("accept_seen", acc, 1);
        @(posedge clk);
        #1;
        if (acc) begin
            if (which) bus.req1_valid = 1'b0;
            else bus.req0_valid = 1'b0;
        end
    endtask

    task automatic wait_resp(input time ta, output int lat, output bit id, output logic [1:0] st);
        bit got;
        got = 1'b0; lat = -1; id = 1'b0; st = 2'b00;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            #1;
            if (rq_t.size() > 0) got = 1'b1;
        end
        chk("resp_seen", got, 1);
        if (got) begin
            lat = int'((rq_t.pop_front() - ta) / 10);
            id = rq_id.pop_front();
            st = rq_st.pop_front();
        end
    endtask

    task automatic run_cmd(input bit rid, input logic [2:0] op, input logic [15:0] sc,
                           input int mode, input int lat,
                           output int o_lat, output bit o_id, output logic [1:0] o_st, output int o_starts);
        int s0;
        bit acc, which;
        time ta;
        alu_mode = mode;
        alu_lat = lat;
        s0 = n_start;
        @(posedge clk);
        #1;
        if (rid) begin bus.req1_opcode = op; bus.req1_scalar = sc; bus.req1_valid = 1'b1; end
        else begin bus.req0_opcode = op; bus.req0_scalar = sc; bus.req0_valid = 1'b1; end
        wait_accept(acc, which, ta);
        wait_resp(ta, o_lat, o_id, o_st);
        o_starts = n_start - s0;
    endtask

    task automatic assert_reset();
        @(negedge clk);
        #2;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst_n = 1'b0;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin : stimulus
        int lat, starts;
        bit id, acc, which;
        logic [1:0] st;
        time ta;
        bit exp_g[3];
        exp_g = '{1'b0, 1'b1, 1'b0};
        bus.req0_valid = 1'b0; bus.req0_opcode = 3'd0; bus.req0_scalar = 16'd0;
        bus.req1_valid = 1'b0; bus.req1_opcode = 3'd0; bus.req1_scalar = 16'd0;
        #1;
        chk("rst_alu_start", bus.alu_start, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_fault", bus.fault, 0);
        chk("rst_ok_count", bus.ok_count, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_req0_ready", bus.req0_ready, 1);
        release_reset();

        // 1: req0 ADD, ALU done after 10 cycles
        run_cmd(1'b0, 3'd0, 16'h0000, M_OK, 10, lat, id, st, starts);
        chk("t1_latency", lat, 13);
        chk("t1_start_cycles", starts, 11);
        chk("t1_id", id, 0);
        chk("t1_status", st, 0);
        @(negedge clk);
        chk("t1_ok_count", bus.ok_count, 1);

        // 3: MUL with a stale error pulse during ISSUE
        run_cmd(1'b0, 3'd2, 16'h1234, M_STALE, 5, lat, id, st, starts);
        chk("t3_latency", lat, 8);
        chk("t3_status", st, 0);

        // 4: illegal opcode from req1
        run_cmd(1'b1, 3'b111, 16'h00ff, M_OK, 3, lat, id, st, starts);
        chk("t4_latency", lat, 1);
        chk("t4_start_cycles", starts, 0);
        chk("t4_id", id, 1);
        chk("t4_status", st, 3);
        @(negedge clk);
        chk("t4_ok_count", bus.ok_count, 2);

        // 2: simultaneous requests, three rounds
        alu_mode = M_OK;
        alu_lat = 3;
        bus.req0_opcode = 3'd0; bus.req0_scalar = 16'h0a0a;
        bus.req1_opcode = 3'd1; bus.req1_scalar = 16'h0b0b;
        for (int r = 0; r < 3; r++) begin
            @(posedge clk);
            #1;
            bus.req0_valid = 1'b1;
            bus.req1_valid = 1'b1;
            wait_accept(acc, which, ta);
            if (r == 2) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            wait_resp(ta, lat, id, st);
            chk($sformatf("t2_grant%0d", r), which, exp_g[r]);
            chk($sformatf("t2_resp_id%0d", r), id, exp_g[r]);
            chk($sformatf("t2_status%0d", r), st, 0);
            chk($sformatf("t2_latency%0d", r), lat, 6);
        end

        // 5: hung ALU trips the watchdog
        run_cmd(1'b0, 3'd4, 16'h0001, M_HANG, 0, lat, id, st, starts);
        chk("t5_latency", lat, 18);
        chk("t5_start_cycles", starts, 17);
        chk("t5_status", st, 2);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_fault", bus.fault, 1);
        chk("t5_req0_ready", bus.req0_ready, 0);
        chk("t5_ok_count", bus.ok_count, 5);

        // 6: reset clears FAULT, then reset again mid-RUN, then a fresh command
        assert_reset();
        #1;
        chk("t6_fault_cleared", bus.fault, 0);
        release_reset();
        alu_mode = M_OK;
        alu_lat = 20;
        @(posedge clk);
        #1;
        bus.req0_opcode = 3'd3; bus.req0_scalar = 16'h0042; bus.req0_valid = 1'b1;
        wait_accept(acc, which, ta);
        repeat (6) @(negedge clk);
        chk("t6_start_before_rst", bus.alu_start, 1);
        assert_reset();
        #1;
        chk("t6_rst_alu_start", bus.alu_start, 0);
        chk("t6_rst_busy", bus.busy, 0);
        chk("t6_rst_resp_valid", bus.resp_valid, 0);
        release_reset();
        run_cmd(1'b0, 3'd1, 16'h0007, M_OK, 4, lat, id, st, starts);
        chk("t6_latency", lat, 7);
        chk("t6_id", id, 0);
        chk("t6_status", st, 0);
        @(negedge clk);
        chk("t6_ok_count", bus.ok_count, 1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin : global_timeout
        #200000;
        n_fail++;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "global timeout");
    end
endmodule
